// File: rtl/boa_id_branch_predictor_pkg.sv
// Boa32 ID-stage branch predictor shared definitions.
// Opcodes, immediate extractors and predictor FSM states.
package boa_id_branch_predictor_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [0:0] bp_state_t;
  localparam bp_state_t BP_INIT = 1'b0;
  localparam bp_state_t BP_RUN  = 1'b1;

  function automatic logic [31:0] imm_j(
    input logic [31:0] i
  );
    return {{12{i[31]}}, i[19:12], i[20],
            i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(
    input logic [31:0] i
  );
    return {{20{i[31]}}, i[7], i[30:25],
            i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/boa_id_branch_predictor_sat_ctr_table.sv
// Saturating-counter table: one async read port,
// one read-modify-write training port, one init port.
module boa_sat_ctr_table
  import boa_id_branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int IDX      = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic [IDX-1:0]      rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                upd_en,
  input  logic [IDX-1:0]      upd_idx,
  input  logic                upd_taken,
  input  logic                init_en,
  input  logic [IDX-1:0]      init_idx,
  input  logic [CTR_BITS-1:0] init_val
);

  localparam logic [CTR_BITS-1:0] MAX = '1;

  logic [CTR_BITS-1:0] mem_q [ENTRIES];
  logic [CTR_BITS-1:0] upd_cur;
  logic [CTR_BITS-1:0] upd_nxt;

  // Read ports and saturating next-counter value
  always_comb begin
    rd_ctr  = mem_q[rd_idx];
    upd_cur = mem_q[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != MAX) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

  // Init sweep writes win over training updates
  always_ff @(posedge clk) begin
    if (init_en)
      mem_q[init_idx] <= init_val;
    else if (upd_en)
      mem_q[upd_idx] <= upd_nxt;
  end

endmodule

// File: rtl/boa_id_branch_predictor.sv
// Boa32 ID-stage dynamic branch predictor.
// BHT (bimodal or gshare), ID/IF redirect, ID/EX register.
module boa_id_branch_predictor
  import boa_id_branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int HIST_BITS   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic [29:0] d_pc,
  input  logic [31:0] d_insn,
  input  logic        fw_stall_id,
  input  logic        fw_stall_ex,
  input  logic        fw_flush,
  output logic        id_branch_predict,
  output logic [29:0] id_branch_target,
  output logic        id_busy,
  output logic        q_valid,
  output logic [29:0] q_pc,
  output logic [31:0] q_insn,
  output logic        q_predicted,
  output logic [(HIST_BITS>0?HIST_BITS:1)-1:0] q_hist,
  input  logic        ex_res_valid,
  input  logic [29:0] ex_res_pc,
  input  logic        ex_res_taken,
  input  logic        ex_res_mispredict,
  input  logic [(HIST_BITS>0?HIST_BITS:1)-1:0] ex_res_hist
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam int HW  = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam int SH  = (HIST_BITS > 0) ? IDX - HIST_BITS : 0;
  localparam logic [CTR_BITS-1:0] WNT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  function automatic logic [IDX-1:0] bht_hash(
    input logic [IDX-1:0] pc,
    input logic [HW-1:0]  h
  );
    logic [IDX-1:0] hx;
    hx = IDX'(h) << SH;
    if (HIST_BITS > 0) return pc ^ hx;
    return pc;
  endfunction

  bp_state_t      state_q, state_d;
  logic [IDX-1:0] sweep_q, sweep_d;
  logic [HW-1:0]  ghr_q, ghr_d;

  logic [6:0]          opcode;
  logic                is_jal, is_br, active, run;
  logic [31:0]         ij, ib;
  logic [29:0]         jal_tgt, br_tgt;
  logic [IDX-1:0]      rd_idx, upd_idx;
  logic [CTR_BITS-1:0] rd_ctr;
  logic [HW:0]         ghr_shift, ghr_fix;
  logic                unused_bits;

  assign unused_bits = ^{ij[1:0], ib[0],
                         ex_res_pc[29:IDX]};

  boa_sat_ctr_table #(
    .ENTRIES (BHT_ENTRIES),
    .CTR_BITS(CTR_BITS),
    .IDX     (IDX)
  ) u_bht (
    .clk      (clk),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .upd_en   (run && ex_res_valid),
    .upd_idx  (upd_idx),
    .upd_taken(ex_res_taken),
    .init_en  (state_q == BP_INIT),
    .init_idx (sweep_q),
    .init_val (WNT)
  );

  // Decode, lookup and redirect in ID
  always_comb begin
    run     = (state_q == BP_RUN);
    id_busy = !run;
    opcode  = d_insn[6:0];
    is_jal  = (opcode == OP_JAL);
    is_br   = (opcode == OP_BRANCH);
    ij      = imm_j(d_insn);
    ib      = imm_b(d_insn);
    jal_tgt = d_pc + ij[31:2];
    br_tgt  = d_pc + ib[31:2];
    active  = d_valid && !fw_stall_id && run;
    rd_idx  = bht_hash(d_pc[IDX-1:0], ghr_q);
    upd_idx = bht_hash(ex_res_pc[IDX-1:0], ex_res_hist);
    id_branch_predict = 1'b0;
    id_branch_target  = '0;
    if (active) begin
      unique case (1'b1)
        is_jal: begin
          id_branch_predict = 1'b1;
          id_branch_target  = jal_tgt;
        end
        is_br: begin
          if (!ib[1] && rd_ctr[CTR_BITS-1]) begin
            id_branch_predict = 1'b1;
            id_branch_target  = br_tgt;
          end
        end
        default: ;
      endcase
    end
  end

  // Sweep FSM and global history next-state
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    ghr_d     = ghr_q;
    ghr_shift = {ghr_q, id_branch_predict};
    ghr_fix   = {ex_res_hist, ex_res_taken};
    if (!run) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == IDX'(BHT_ENTRIES - 1))
        state_d = BP_RUN;
    end
    if (run && active && is_br)
      ghr_d = ghr_shift[HW-1:0];
    if (run && ex_res_valid && ex_res_mispredict)
      ghr_d = ghr_fix[HW-1:0];
    if (HIST_BITS == 0)
      ghr_d = '0;
  end

  // FSM, sweep index and history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BP_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // ID/EX register: flush, hold, bubble or capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_valid     <= 1'b0;
      q_pc        <= '0;
      q_insn      <= '0;
      q_predicted <= 1'b0;
      q_hist      <= '0;
    end else if (fw_flush) begin
      q_valid     <= 1'b0;
    end else if (fw_stall_ex) begin
      q_valid     <= q_valid;
    end else if (fw_stall_id) begin
      q_valid     <= 1'b0;
    end else begin
      q_valid     <= d_valid;
      q_pc        <= d_pc;
      q_insn      <= d_insn;
      q_predicted <= id_branch_predict;
      q_hist      <= ghr_q;
    end
  end

endmodule

// File: tb/tb_boa_id_branch_predictor.sv
// Directed bench for the ID branch predictor.
// Bimodal instance plus a HIST_BITS=4 gshare instance.
module tb_boa_id_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, d_valid;
  logic [29:0] d_pc;
  logic [31:0] d_insn;
  logic        fw_stall_id, fw_stall_ex, fw_flush;
  logic        ex_res_valid, ex_res_taken;
  logic        ex_res_mispredict;
  logic [29:0] ex_res_pc;
  logic [3:0]  ex_res_hist;

  logic        a_pred, a_busy, a_qv, a_qpred;
  logic [29:0] a_tgt, a_qpc;
  logic [31:0] a_qinsn;
  logic [0:0]  a_qhist;
  logic        b_pred, b_busy, b_qv, b_qpred;
  logic [29:0] b_tgt, b_qpc;
  logic [31:0] b_qinsn;
  logic [3:0]  b_qhist;

  localparam logic [31:0] I_BR16 = 32'h0000_0863;
  localparam logic [31:0] I_BRM  = 32'h0000_0163;
  localparam logic [31:0] I_JAL  = 32'h0200_006F;
  localparam logic [31:0] I_JALR = 32'h0000_8067;
  localparam logic [31:0] I_NOP  = 32'h0000_0013;

  int checks = 0;
  int failures = 0;

  boa_id_branch_predictor u_a (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn),
    .fw_stall_id(fw_stall_id),
    .fw_stall_ex(fw_stall_ex),
    .fw_flush(fw_flush),
    .id_branch_predict(a_pred),
    .id_branch_target(a_tgt),
    .id_busy(a_busy),
    .q_valid(a_qv), .q_pc(a_qpc), .q_insn(a_qinsn),
    .q_predicted(a_qpred), .q_hist(a_qhist),
    .ex_res_valid(ex_res_valid),
    .ex_res_pc(ex_res_pc),
    .ex_res_taken(ex_res_taken),
    .ex_res_mispredict(ex_res_mispredict),
    .ex_res_hist(ex_res_hist[0:0])
  );

  boa_id_branch_predictor #(.HIST_BITS(4)) u_b (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn),
    .fw_stall_id(fw_stall_id),
    .fw_stall_ex(fw_stall_ex),
    .fw_flush(fw_flush),
    .id_branch_predict(b_pred),
    .id_branch_target(b_tgt),
    .id_busy(b_busy),
    .q_valid(b_qv), .q_pc(b_qpc), .q_insn(b_qinsn),
    .q_predicted(b_qpred), .q_hist(b_qhist),
    .ex_res_valid(ex_res_valid),
    .ex_res_pc(ex_res_pc),
    .ex_res_taken(ex_res_taken),
    .ex_res_mispredict(ex_res_mispredict),
    .ex_res_hist(ex_res_hist)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v,
                       input logic [29:0] pc,
                       input logic [31:0] insn);
    d_valid = v;
    d_pc    = pc;
    d_insn  = insn;
    #1;
  endtask

  task automatic train(input logic [29:0] pc,
                       input logic taken);
    d_valid      = 1'b0;
    ex_res_valid = 1'b1;
    ex_res_pc    = pc;
    ex_res_taken = taken;
    ex_res_hist  = 4'h0;
    tick;
    ex_res_valid = 1'b0;
  endtask

  task automatic do_reset;
    int n;
    int bad;
    rst = 1'b0;
    fw_stall_id = 0; fw_stall_ex = 0; fw_flush = 0;
    ex_res_valid = 0; ex_res_taken = 0;
    ex_res_mispredict = 0; ex_res_pc = '0;
    ex_res_hist = '0;
    d_valid = 1'b1; d_pc = 30'h10; d_insn = I_JAL;
    repeat (3) tick;
    chk("rst_qv", 32'(a_qv), 32'd0);
    chk("rst_pred", 32'(a_pred), 32'd0);
    chk("rst_qhist", 32'(b_qhist), 32'd0);
    rst = 1'b1;
    n = 0;
    bad = 0;
    while (a_busy && n < 200) begin
      if (a_pred || b_pred) bad++;
      n++;
      tick;
    end
    chk("busy_cycles", 32'(n), 32'd64);
    chk("busy_pred", 32'(bad), 32'd0);
    chk("post_init_jal", 32'(a_pred), 32'd1);
    d_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset;

    set_d(1, 30'h40, I_BR16);
    chk("br_fresh", 32'(a_pred), 32'd0);
    train(30'h40, 1);
    train(30'h40, 1);
    set_d(1, 30'h40, I_BR16);
    chk("br_trained", 32'(a_pred), 32'd1);
    chk("br_target", 32'(a_tgt), 32'h44);
    tick;
    chk("q_pred", 32'(a_qpred), 32'd1);
    chk("q_pc", 32'(a_qpc), 32'h40);
    set_d(1, 30'h40, I_BRM);
    chk("br_misalign", 32'(a_pred), 32'd0);

    for (int i = 0; i < 5; i++) train(30'h41, 1);
    train(30'h41, 0);
    set_d(1, 30'h41, I_BR16);
    chk("sat_high", 32'(a_pred), 32'd1);
    for (int i = 0; i < 4; i++) train(30'h42, 0);
    set_d(1, 30'h42, I_BR16);
    chk("sat_zero", 32'(a_pred), 32'd0);
    train(30'h42, 1);
    set_d(1, 30'h42, I_BR16);
    chk("sat_low", 32'(a_pred), 32'd0);
    train(30'h42, 1);
    set_d(1, 30'h42, I_BR16);
    chk("sat_up", 32'(a_pred), 32'd1);

    set_d(1, 30'h3FFF_FFFC, I_JAL);
    chk("jal_pred", 32'(a_pred), 32'd1);
    chk("jal_wrap", 32'(a_tgt), 32'h4);
    fw_stall_id = 1'b1;
    #1;
    chk("jal_stall", 32'(a_pred), 32'd0);
    fw_stall_id = 1'b0;
    set_d(0, 30'h3FFF_FFFC, I_JAL);
    chk("jal_novalid", 32'(a_pred), 32'd0);
    set_d(1, 30'h20, I_JALR);
    chk("jalr", 32'(a_pred), 32'd0);

    set_d(1, 30'h50, I_NOP);
    tick;
    chk("cap_qv", 32'(a_qv), 32'd1);
    chk("cap_pc", 32'(a_qpc), 32'h50);
    fw_stall_ex = 1'b1;
    set_d(1, 30'h60, I_JAL);
    tick;
    chk("hold_pc", 32'(a_qpc), 32'h50);
    chk("hold_insn", a_qinsn, I_NOP);
    chk("hold_qv", 32'(a_qv), 32'd1);
    fw_stall_ex = 1'b0;
    fw_stall_id = 1'b1;
    tick;
    chk("bubble_qv", 32'(a_qv), 32'd0);
    fw_stall_id = 1'b0;
    tick;
    chk("recap_qv", 32'(a_qv), 32'd1);
    fw_flush = 1'b1;
    fw_stall_ex = 1'b1;
    tick;
    chk("flush_qv", 32'(a_qv), 32'd0);
    fw_flush = 1'b0;
    fw_stall_ex = 1'b0;

    ex_res_valid = 1'b1;
    ex_res_pc = 30'h43;
    ex_res_taken = 1'b1;
    ex_res_hist = 4'h0;
    set_d(1, 30'h43, I_BR16);
    chk("same_idx_old", 32'(a_pred), 32'd0);
    tick;
    ex_res_valid = 1'b0;
    #1;
    chk("same_idx_new", 32'(a_pred), 32'd1);

    do_reset;
    train(30'h44, 1);
    train(30'h44, 1);
    set_d(1, 30'h44, I_BR16);
    chk("gs_pred", 32'(b_pred), 32'd1);
    tick;
    set_d(1, 30'h0, I_NOP);
    chk("gs_snap0", 32'(b_qhist), 32'h0);
    tick;
    chk("gs_shift", 32'(b_qhist), 32'h1);
    ex_res_valid = 1'b1;
    ex_res_mispredict = 1'b1;
    ex_res_hist = 4'b1010;
    ex_res_taken = 1'b0;
    ex_res_pc = 30'h99;
    set_d(1, 30'h44, I_BR16);
    tick;
    ex_res_valid = 1'b0;
    ex_res_mispredict = 1'b0;
    set_d(1, 30'h0, I_NOP);
    chk("gs_prerepair", 32'(b_qhist), 32'h1);
    tick;
    chk("gs_repair", 32'(b_qhist), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
